ssi_encoder_reader: RTL and testbench

Parametrised SSI master for reading absolute rotary encoders. It drives one shared SCK to `NCH` encoders and shifts `DATA_W` bits MSB-first from each MISO line. It optionally converts Gray code to binary, enforces the encoder monoflop recovery time, and flags line faults per channel. It replaces the fixed two-channel 13-bit reader and sits between the frame-timing logic (source of `start`) and the position registers.

---
 rtl/ssi_encoder_reader_pkg.sv | 37 +++
 rtl/ssi_encoder_reader_if.sv | 22 ++
 rtl/ssi_encoder_reader_shift_channel.sv | 67 ++++++
 rtl/ssi_encoder_reader.sv | 138 +++++++++++++
 tb/tb_ssi_encoder_reader.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssi_encoder_reader_pkg.sv
// ssi_enc_pkg: shared types and helpers for the SSI encoder reader.
//   ssi_state_e  - frame sequencer states, with legacy logic [1:0] aliases
//   cnt_w()      - counter width able to hold the values 0..n-1
//   gray2bin()   - Gray to binary conversion on a zero-extended word
package ssi_enc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    MONO  = 2'd3
  } ssi_state_e;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_LATCH = LATCH;
  localparam logic [1:0] ST_MONO  = MONO;

  localparam int MAX_DATA_W = 32;

  // Bits needed to count 0..n-1; never below 1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Caller zero-extends a narrower word. The leading zeros leave the top
  // real bit unchanged (b[W-1] = g[W-1]), so one width serves every DATA_W.
  function automatic logic [MAX_DATA_W-1:0] gray2bin(input logic [MAX_DATA_W-1:0] g);
    logic [MAX_DATA_W-1:0] b;
    b[MAX_DATA_W-1] = g[MAX_DATA_W-1];
    for (int k = MAX_DATA_W - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

endpackage

// File: rtl/ssi_encoder_reader_if.sv
// Host-side bus of the SSI encoder reader.
//   start    - frame request from the frame-timing logic
//   valid    - one-cycle pulse when enc_data/err update
//   busy     - frame in progress (SHIFT, LATCH, MONO)
//   enc_data - channel i in bits [i*DATA_W +: DATA_W]
//   err      - per-channel line fault from the last frame
// master: frame-timing / position-register side. slave: the reader.
interface ssi_encoder_reader_if #(
  parameter int NCH    = 2,
  parameter int DATA_W = 13
) ();

  logic                    start;
  logic                    valid;
  logic                    busy;
  logic [NCH*DATA_W-1:0]   enc_data;
  logic [NCH-1:0]          err;

  modport master (output start, input valid, busy, enc_data, err);
  modport slave  (input start, output valid, busy, enc_data, err);

endinterface

// File: rtl/ssi_encoder_reader_shift_channel.sv
// ssi_shift_channel: one encoder channel of the SSI reader.
//   clk, rst_n  - CLK_10MHZ and synchronous active-low reset
//   miso        - this channel's encoder data line
//   frame_go    - frame accepted this cycle; captures idle-line level
//   shift_en    - SCK rising edge; shift miso in
//   latch_en    - LATCH cycle; load output register and fault flag
//   mono_last   - final MONO cycle; a still-low line sets the fault
//   data, err   - registered position word and line fault
module ssi_shift_channel
  import ssi_enc_pkg::*;
#(
  parameter int DATA_W = 13,
  parameter int GRAY   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miso,
  input  logic              frame_go,
  input  logic              shift_en,
  input  logic              latch_en,
  input  logic              mono_last,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  logic [DATA_W-1:0]     sr;
  logic                  err_cap;
  logic [MAX_DATA_W-1:0] bin_full;
  logic [DATA_W-1:0]     data_next;
  logic                  unused_bin;

  always_comb begin
    bin_full  = gray2bin(MAX_DATA_W'(sr));
    data_next = sr;
    if (GRAY != 0) begin
      data_next = bin_full[DATA_W-1:0];
    end
  end

  // Upper bits are always zero for narrow words.
  assign unused_bin = ^bin_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr      <= '0;
      err_cap <= 1'b0;
      data    <= '0;
      err     <= 1'b0;
    end else begin
      // An idle line should be high; low means broken wire or encoder
      // still in its monoflop time.
      if (frame_go) begin
        err_cap <= ~miso;
      end
      if (shift_en) begin
        sr <= {sr[DATA_W-2:0], miso};
      end
      if (latch_en) begin
        data <= data_next;
        err  <= err_cap;
      end else if (mono_last && !miso) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssi_encoder_reader.sv
// ssi_encoder_reader: SSI master for NCH absolute encoders on one shared SCK.
//   CLK_10MHZ  - sole clock
//   RST_N      - synchronous active-low reset
//   ENC_SCK    - shared SSI clock, idle high, registered
//   ENC_MISO   - encoder data, bit i is channel i
//   host       - start/valid/busy/enc_data/err bus (slave side)
//
// state | meaning
// IDLE  | SCK high, waiting for start
// SHIFT | SCK running, DATA_W low pulses, sample on rising edges
// LATCH | one cycle, load outputs and pulse valid
// MONO  | SCK held high for T_MONO cycles of encoder recovery
module ssi_encoder_reader
  import ssi_enc_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int DATA_W   = 13,
  parameter int HALF_DIV = 5,
  parameter int GRAY     = 0,
  parameter int T_MONO   = 250
) (
  input  logic                 CLK_10MHZ,
  input  logic                 RST_N,
  output logic                 ENC_SCK,
  input  logic [NCH-1:0]       ENC_MISO,
  ssi_encoder_reader_if.slave  host
);

  localparam int DIV_W  = cnt_w(HALF_DIV);
  localparam int BIT_W  = cnt_w(DATA_W + 1);
  localparam int MONO_W = cnt_w(T_MONO);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_ALL   = BIT_W'(DATA_W);
  localparam logic [MONO_W-1:0] MONO_LOAD = MONO_W'(T_MONO - 1);

  logic [1:0]            state;
  logic [DIV_W-1:0]      div;
  logic [BIT_W-1:0]      bitcnt;
  logic [MONO_W-1:0]     mcnt;
  logic                  sck;
  logic                  valid_q;
  logic                  div_tc;
  logic                  frame_go;
  logic                  shift_en;
  logic                  latch_en;
  logic                  mono_last;
  logic [NCH*DATA_W-1:0] data_all;

  always_comb begin
    div_tc    = (div == DIV_LAST);
    frame_go  = (state == ST_IDLE) && host.start;
    shift_en  = (state == ST_SHIFT) && div_tc && !sck;
    latch_en  = (state == ST_LATCH);
    mono_last = (state == ST_MONO) && (mcnt == '0);
  end

  always_ff @(posedge CLK_10MHZ) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      sck     <= 1'b1;
      div     <= '0;
      bitcnt  <= '0;
      mcnt    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          sck <= 1'b1;
          if (host.start) begin
            state  <= ST_SHIFT;
            sck    <= 1'b0;
            div    <= '0;
            bitcnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (div_tc) begin
            div <= '0;
            if (!sck) begin
              sck    <= 1'b1;
              bitcnt <= bitcnt + 1'b1;
            end else if (bitcnt == BIT_ALL) begin
              // Last high half-period done: SCK stays high into LATCH.
              state <= ST_LATCH;
            end else begin
              sck <= 1'b0;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        ST_LATCH: begin
          sck     <= 1'b1;
          valid_q <= 1'b1;
          mcnt    <= MONO_LOAD;
          state   <= ST_MONO;
        end
        ST_MONO: begin
          sck <= 1'b1;
          if (mcnt == '0) begin
            state <= ST_IDLE;
          end else begin
            mcnt <= mcnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          sck   <= 1'b1;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ssi_shift_channel #(
      .DATA_W (DATA_W),
      .GRAY   (GRAY)
    ) u_ch (
      .clk       (CLK_10MHZ),
      .rst_n     (RST_N),
      .miso      (ENC_MISO[i]),
      .frame_go  (frame_go),
      .shift_en  (shift_en),
      .latch_en  (latch_en),
      .mono_last (mono_last),
      .data      (data_all[i*DATA_W +: DATA_W]),
      .err       (host.err[i])
    );
  end

  assign ENC_SCK       = sck;
  assign host.valid    = valid_q;
  assign host.busy     = (state != ST_IDLE);
  assign host.enc_data = data_all;

endmodule

// File: tb/tb_ssi_encoder_reader.sv
module tb_ssi_encoder_reader;

  localparam int ND = 3;
  localparam int P_NCH  [ND] = '{2, 1, 4};
  localparam int P_DW   [ND] = '{13, 8, 10};
  localparam int P_H    [ND] = '{5, 2, 2};
  localparam int P_GRAY [ND] = '{0, 1, 0};
  localparam int P_T    [ND] = '{250, 3, 1};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [ND-1:0] start_a = '0;
  logic [ND-1:0] sck_a;
  logic [ND-1:0] busy_a;
  logic [ND-1:0] valid_a;
  logic [ND-1:0] prev_sck = '1;
  logic [3:0]    miso_a [ND];
  logic [3:0]    drv [ND];
  logic [3:0]    stuck [ND];
  logic [3:0]    err_a [ND];
  logic [127:0]  data_a [ND];
  logic [31:0]   word [ND][4];
  int            bitn [ND];
  int            fall_cnt [ND];
  int            n_chk = 0;
  int            n_err = 0;

  always #50 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    ssi_encoder_reader_if #(.NCH(P_NCH[d]), .DATA_W(P_DW[d])) bus ();
    assign bus.start = start_a[d];
    assign miso_a[d] = drv[d] & ~stuck[d];
    ssi_encoder_reader #(
      .NCH      (P_NCH[d]),
      .DATA_W   (P_DW[d]),
      .HALF_DIV (P_H[d]),
      .GRAY     (P_GRAY[d]),
      .T_MONO   (P_T[d])
    ) u_dut (
      .CLK_10MHZ (clk),
      .RST_N     (rst_n),
      .ENC_SCK   (sck_a[d]),
      .ENC_MISO  (miso_a[d][P_NCH[d]-1:0]),
      .host      (bus)
    );
    assign busy_a[d]  = bus.busy;
    assign valid_a[d] = bus.valid;
    assign err_a[d]   = 4'(bus.err);
    assign data_a[d]  = 128'(bus.enc_data);
  end

  // Encoder model: idle high, presents the next bit MSB-first on each SCK
  // fall, returns high after the last bit is clocked out.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!busy_a[d]) begin
        bitn[d] = 0;
        drv[d]  = '1;
      end else if (prev_sck[d] && !sck_a[d]) begin
        for (int c = 0; c < P_NCH[d]; c++) begin
          drv[d][c] = word[d][c][P_DW[d]-1-bitn[d]];
        end
        bitn[d]++;
        fall_cnt[d]++;
      end else if (!prev_sck[d] && sck_a[d] && bitn[d] == P_DW[d]) begin
        drv[d] = '1;
      end
      prev_sck[d] = sck_a[d];
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mask(input int d);
    return (32'd1 << P_DW[d]) - 32'd1;
  endfunction

  function automatic logic [31:0] g2b(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int s = 0; s < 32; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [127:0] exp_data(input int d);
    logic [127:0] v;
    logic [31:0]  w;
    v = '0;
    for (int c = 0; c < P_NCH[d]; c++) begin
      w = word[d][c] & mask(d);
      if (stuck[d][c]) w = '0;
      else if (P_GRAY[d] != 0) w = g2b(w);
      v = v | (128'(w) << (c * P_DW[d]));
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_err(input int d);
    return stuck[d] & 4'((1 << P_NCH[d]) - 1);
  endfunction

  task automatic run_frame(input int d);
    int base, n, m, lat;
    lat = 2 * P_DW[d] * P_H[d] + 1;
    @(negedge clk);
    base = fall_cnt[d];
    start_a[d] = 1'b1;
    tick();
    start_a[d] = 1'b0;
    chk($sformatf("d%0d_busy_start", d), 128'(busy_a[d]), 128'(1));
    chk($sformatf("d%0d_sck_low_start", d), 128'(sck_a[d]), 128'(0));
    n = 1;
    while (n <= lat + 50) begin
      tick();
      if (valid_a[d]) break;
      n++;
    end
    chk($sformatf("d%0d_valid_latency", d), 128'(n), 128'(lat));
    chk($sformatf("d%0d_sck_pulses", d), 128'(fall_cnt[d] - base), 128'(P_DW[d]));
    chk($sformatf("d%0d_enc_data", d), data_a[d], exp_data(d));
    chk($sformatf("d%0d_err", d), 128'(err_a[d]), 128'(exp_err(d)));
    chk($sformatf("d%0d_sck_high_latch", d), 128'(sck_a[d]), 128'(1));
    m = 0;
    do begin
      tick();
      m++;
      if (m == 1) chk($sformatf("d%0d_valid_one_cycle", d), 128'(valid_a[d]), 128'(0));
    end while (busy_a[d] && m < P_T[d] + 50);
    chk($sformatf("d%0d_mono_len", d), 128'(m), 128'(P_T[d]));
  endtask

  task automatic back_to_back(input int d);
    int cyc, period;
    int rises[$];
    logic pb;
    period = 2 * P_DW[d] * P_H[d] + P_T[d] + 2;
    cyc = 0;
    @(negedge clk);
    start_a[d] = 1'b1;
    pb = busy_a[d];
    while (rises.size() < 3 && cyc < 4 * period) begin
      tick();
      cyc++;
      if (busy_a[d] && !pb) rises.push_back(cyc);
      pb = busy_a[d];
    end
    start_a[d] = 1'b0;
    chk($sformatf("d%0d_b2b_frames", d), 128'(rises.size()), 128'(3));
    if (rises.size() == 3) begin
      chk($sformatf("d%0d_b2b_period1", d), 128'(rises[1] - rises[0]), 128'(period));
      chk($sformatf("d%0d_b2b_period2", d), 128'(rises[2] - rises[1]), 128'(period));
    end
    cyc = 0;
    while (busy_a[d] && cyc < 2 * period) begin
      tick();
      cyc++;
    end
    chk($sformatf("d%0d_b2b_idle", d), 128'(busy_a[d]), 128'(0));
    chk($sformatf("d%0d_b2b_data", d), data_a[d], exp_data(d));
  endtask

  task automatic mono_pulse(input int d);
    int cyc, extra;
    @(negedge clk);
    start_a[d] = 1'b1;
    tick();
    start_a[d] = 1'b0;
    cyc = 0;
    while (!valid_a[d] && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk($sformatf("d%0d_mono_valid_seen", d), 128'(valid_a[d]), 128'(1));
    repeat (3) @(negedge clk);
    start_a[d] = 1'b1;
    @(negedge clk);
    start_a[d] = 1'b0;
    repeat (P_T[d] / 2) @(negedge clk);
    start_a[d] = 1'b1;
    @(negedge clk);
    start_a[d] = 1'b0;
    cyc = 0;
    while (busy_a[d] && cyc < 1000) begin
      tick();
      cyc++;
    end
    extra = 0;
    repeat (20) begin
      tick();
      if (busy_a[d] || valid_a[d]) extra++;
    end
    chk($sformatf("d%0d_no_queued_start", d), 128'(extra), 128'(0));
  endtask

  task automatic reset_mid(input int d);
    int base, cyc, bad;
    @(negedge clk);
    base = fall_cnt[d];
    start_a[d] = 1'b1;
    tick();
    start_a[d] = 1'b0;
    cyc = 0;
    while (fall_cnt[d] - base < 7 && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk("rst_mid_reached_bit6", 128'(fall_cnt[d] - base), 128'(7));
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_sck", 128'(sck_a[d]), 128'(1));
    chk("rst_mid_busy", 128'(busy_a[d]), 128'(0));
    chk("rst_mid_data", data_a[d], 128'(0));
    bad = 0;
    repeat (2) begin
      tick();
      if (valid_a[d]) bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      if (valid_a[d] || busy_a[d]) bad++;
    end
    chk("rst_mid_no_valid", 128'(bad), 128'(0));
    chk("rst_mid_err", 128'(err_a[d]), 128'(0));
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      stuck[d] = '0;
      for (int c = 0; c < 4; c++) word[d][c] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d_rst_sck", d), 128'(sck_a[d]), 128'(1));
      chk($sformatf("d%0d_rst_valid", d), 128'(valid_a[d]), 128'(0));
      chk($sformatf("d%0d_rst_busy", d), 128'(busy_a[d]), 128'(0));
      chk($sformatf("d%0d_rst_err", d), 128'(err_a[d]), 128'(0));
      chk($sformatf("d%0d_rst_data", d), data_a[d], 128'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    word[0][0] = 32'h1ABC;
    word[0][1] = 32'h0555;
    run_frame(0);
    chk("default_frame_data", data_a[0], 128'({13'h0555, 13'h1ABC}));

    word[1][0] = 32'hC8;
    run_frame(1);
    chk("gray_c8", data_a[1], 128'(8'h8F));

    word[2][0] = 32'h3A5;
    word[2][1] = 32'h0F0;
    word[2][2] = 32'h155;
    word[2][3] = 32'h2C3;
    run_frame(2);

    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < ND; d++) begin
        for (int c = 0; c < 4; c++) word[d][c] = $urandom & mask(d);
        if (d == 2) stuck[2] = 4'($urandom_range(0, 15));
        run_frame(d);
      end
    end
    stuck[2] = '0;

    word[0][0] = $urandom & mask(0);
    word[0][1] = $urandom & mask(0);
    stuck[0] = 4'b0010;
    run_frame(0);
    chk("fault_err_ch1", 128'(err_a[0]), 128'(2'b10));
    chk("fault_data_ch1_zero", 128'(data_a[0][25:13]), 128'(0));
    stuck[0] = '0;
    run_frame(0);
    chk("fault_cleared", 128'(err_a[0]), 128'(0));

    back_to_back(0);
    back_to_back(2);
    mono_pulse(0);
    reset_mid(0);
    run_frame(0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
